// File: rtl/viterbi_acs_array.sv
// rtl/viterbi_acs_array.sv - add-compare-select array for one Viterbi trellis step per NS-beat frame
//
// Purpose: NS parallel max-plus lanes. Beat i carries delta[n-1,i] and row logA[i][*].
// Each lane j keeps the running maximum of delta + logA[i][j] and its argmax i. On the last
// beat it adds logB[j] and loads the result plus the survivor index into the output register.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   clear             aborts the frame being accumulated; the output register is left alone
//   in_valid/in_ready beat handshake
//   in_delta          delta[n-1,i] of the current beat
//   in_logA           logA[i][j], lane j at [j*FW +: FW]
//   in_logB           logB[j], lane j at [j*FW +: FW], used on the last beat only
//   out_valid/ready   result handshake
//   out_delta         delta[n,j], lane j at [j*FW +: FW]
//   out_psi           survivor index of lane j at [j*IW +: IW]
//   busy              registered, high while a frame is partially accumulated
module viterbi_acs_array #(
  parameter int FW = 16,
  parameter int NS = 8,
  localparam int IW = $clog2(NS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FW-1:0]    in_delta,
  input  logic [NS*FW-1:0] in_logA,
  input  logic [NS*FW-1:0] in_logB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NS*FW-1:0] out_delta,
  output logic [NS*IW-1:0] out_psi,
  output logic             busy
);

  // Clamp an FW+1 bit sum back to FW bits. Overflow shows up as the two top bits differing.
  function automatic logic signed [FW-1:0] sat(input logic signed [FW:0] x);
    if (x[FW] != x[FW-1]) begin
      return x[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
    end
    return x[FW-1:0];
  endfunction

  logic [IW-1:0] cnt;
  logic [IW-1:0] cnt_next;
  logic          last_beat;
  logic          accept;
  logic          lane_en;
  logic          load_out;

  wire [NS*FW-1:0] res_flat;
  wire [NS*IW-1:0] win_idx_flat;

  assign last_beat = (cnt == IW'(NS - 1));
  // Only the last beat can stall, and only if the held result is not leaving this cycle.
  assign in_ready  = !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  // A beat coinciding with clear is dropped.
  assign lane_en   = accept && !clear;
  assign load_out  = lane_en && last_beat;

  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = last_beat ? '0 : cnt + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

  for (genvar j = 0; j < NS; j++) begin : g_lane
    logic        [FW-1:0] lane_a;
    logic        [FW-1:0] lane_b;
    logic signed [FW-1:0] s;
    logic signed [FW-1:0] acc;
    logic        [IW-1:0] idx;
    logic signed [FW-1:0] win;
    logic        [IW-1:0] win_idx;
    logic signed [FW-1:0] res;

    assign lane_a = in_logA[j*FW +: FW];
    assign lane_b = in_logB[j*FW +: FW];

    always_comb begin
      s = sat($signed({in_delta[FW-1], in_delta}) + $signed({lane_a[FW-1], lane_a}));
      // Beat 0 always overwrites; later beats need a strict win so ties keep the lower index.
      // In both taken cases the new index equals cnt (which is 0 on the first beat).
      if (cnt == '0 || s > acc) begin
        win     = s;
        win_idx = cnt;
      end else begin
        win     = acc;
        win_idx = idx;
      end
      res = sat($signed({win[FW-1], win}) + $signed({lane_b[FW-1], lane_b}));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
        idx <= '0;
      end else if (lane_en) begin
        acc <= win;
        idx <= win_idx;
      end
    end

    assign res_flat[j*FW +: FW]     = res;
    assign win_idx_flat[j*IW +: IW] = win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_delta <= '0;
      out_psi   <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_delta <= res_flat;
      out_psi   <= win_idx_flat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/viterbi_acs_array.md
# viterbi_acs_array

Parametrised add-compare-select array for the Viterbi decoder: NS parallel max-plus lanes compute one full trellis step (all destination states j) per frame of NS input beats. Beat i supplies δ[n-1,i] and row logA[i][0..NS-1]. The array outputs δ[n,j] = max_i(δ[n-1,i] + logA[i][j]) + logB[j] and the survivor index ψ[n,j], both with saturation. It sits between the δ-memory streamer and the traceback buffer, with valid/ready on both sides.

## Interface
- FW, 16: signed fixed-point width of δ, logA, logB.
- NS, 8: number of trellis states; lanes and beats per frame (NS ≥ 2).
- IW, $clog2(NS): survivor index width (derived, not overridden).
- clk  in  1  single clock, rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- clear  in  1  synchronous abort of the current frame; output register untouched.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_delta  in  FW  δ[n-1,i] for the current beat i.
- in_logA  in  NS*FW  logA[i][j], lane j at bits [j*FW +: FW].
- in_logB  in  NS*FW  emission logB[j]; sampled only on the last beat (i = NS-1).
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer accepts the result.
- out_delta  out  NS*FW  δ[n,j], packed like in_logA.
- out_psi  out  NS*IW  argmax i for lane j, lane j at [j*IW +: IW].
- busy  out  1  high while beat counter ≠ 0, i.e. a frame is partially accumulated.

## Operation
- Beat counter cnt (IW bits) counts accepted beats 0..NS-1 and wraps to 0 after beat NS-1.
- Each lane j keeps an accumulator acc_j (FW bits) and an index idx_j (IW bits).
- Sum: s = δ + logA, computed in FW+1 bits and saturated to [-2^(FW-1), 2^(FW-1)-1].
- Beat with cnt = 0: acc_j ← s_j and idx_j ← 0, unconditionally.
- Beat with cnt > 0: if s_j > acc_j (signed, strict) then acc_j ← s_j and idx_j ← cnt. Ties keep the lower index.
- Last beat (cnt = NS-1):
  - Final compare is done combinationally.
  - winner_j + logB_j is saturated to FW bits and loaded into out_delta; the winning index is loaded into out_psi.
  - out_valid ← 1 and cnt ← 0.
- States:
  - IDLE (cnt = 0, out_valid = 0).
  - ACC (cnt ≠ 0).
  - FULL (out_valid = 1).
  - ACC and FULL can coexist: the next frame accumulates while the result is held.
- in_ready = !(cnt == NS-1 && out_valid && !out_ready). Only the last beat stalls, and only when the output register is occupied and not draining this cycle.
- Output handshake:
  - out_valid && out_ready with no simultaneous last beat → out_valid ← 0.
  - Both in the same cycle → the new result is loaded and out_valid stays 1.
- clear: cnt ← 0 and accumulators are discarded. A beat accepted in the same cycle as clear is dropped. out_valid, out_delta and out_psi are unaffected.
- rst: cnt = 0, all acc/idx = 0, out_valid = 0, out_delta = 0, out_psi = 0, busy = 0. in_ready is 1 after reset because its condition evaluates true.
- rst mid-frame discards the partial frame and any held result. rst has priority over clear and over all handshakes.

## Timing
- Throughput: one frame per NS accepted beats, with no bubble between frames.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible in the following cycle.
- out_delta and out_psi are stable while out_valid && !out_ready.
- in_ready is combinational from cnt, out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- busy is registered, derived from cnt.

## Test plan
- Basic max-plus (NS=4, FW=8):
  - Stimulus: δ = {0,5,-3,2}; logA[i][0] = {1,-10,20,0}; logB[0] = 1; other lanes zero.
  - Required: out_delta[0] = 18, out_psi[0] = 2; out_valid high exactly one cycle after beat 3.
- Ties and saturation:
  - Stimulus: all sums equal 7.
  - Required: out_psi = 0 in every lane.
  - Stimulus: δ = 127, logA = 100, logB = 10.
  - Required: out_delta = 127. The negative case (-128, -100, -10) gives -128.
- Back-pressure:
  - Stimulus: hold out_ready = 0, stream a second frame.
  - Required: in_ready drops only at the second frame's beat 3; the first result stays unchanged.
  - Stimulus: raise out_ready.
  - Required: the last beat is accepted in the same cycle, and the second result appears with out_valid continuously high.
- clear mid-frame:
  - Stimulus: after 2 beats assert clear with in_valid = 1, then send a full frame.
  - Required: the result equals the reference computed on the new frame only; busy = 0 the cycle after clear.
- Reset:
  - Stimulus: rst asserted during beat 2 with a result held.
  - Required: next cycle out_valid = 0, out_delta = 0, out_psi = 0, busy = 0, in_ready = 1.
- Random regression:
  - Stimulus: NS = 8, FW = 16, 1000 frames with random valid/ready gaps.
  - Required: outputs match a scoreboard model bit-exactly.
